// File: rtl/sample_packetizer.sv
// Sample packetizer: buffers 16-bit samples in a FIFO and frames them into
// byte packets (SYNC, SEQ, sample bytes MSB first, XOR checksum) for a UART
// transmitter using a DV / one-cycle tready handshake.
module sample_packetizer #(
    parameter int unsigned PKT_SAMPLES = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic [15:0]                   i_Sample,
    input  logic                          i_Sample_Valid,
    output logic                          o_TX_DV,
    output logic [7:0]                    o_TX_Byte,
    input  logic                          i_TX_Byte_tready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow,
    output logic                          o_Pkt_Active
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEQ,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM
    } state_t;

    // FIFO storage and bookkeeping
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // Packet engine state
    state_t        r_state;
    logic          r_gap;
    logic          r_tx_dv;
    logic [7:0]    r_tx_byte;
    logic          r_pkt_active;
    logic [7:0]    r_seq;
    logic [7:0]    r_csum;
    logic [SW-1:0] r_samp_cnt;

    logic [15:0]   w_head;
    logic          w_accept;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic          w_pkt_ready;
    logic          w_last_sample;
    logic [7:0]    w_state_byte;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_accept      = r_tx_dv & i_TX_Byte_tready;
    assign w_pop         = w_accept & (r_state == S_DATA_LO);
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the incoming sample needs.
    assign w_push        = i_Sample_Valid & (~w_full | w_pop);
    assign w_drop        = i_Sample_Valid & w_full & ~w_pop;
    assign w_pkt_ready   = (r_count >= CW'(PKT_SAMPLES));
    assign w_last_sample = (r_samp_cnt == SW'(PKT_SAMPLES - 1));

    assign o_TX_DV       = r_tx_dv;
    assign o_TX_Byte     = r_tx_byte;
    assign o_Fifo_Count  = r_count;
    assign o_Overflow    = r_overflow;
    assign o_Pkt_Active  = r_pkt_active;

    // Byte belonging to the current state, loaded when a byte is (re)presented
    always_comb begin
        w_state_byte = 8'h00;
        case (r_state)
            S_HDR:     w_state_byte = SYNC_BYTE;
            S_SEQ:     w_state_byte = r_seq;
            S_DATA_HI: w_state_byte = w_head[15:8];
            S_DATA_LO: w_state_byte = w_head[7:0];
            S_CSUM:    w_state_byte = r_csum;
            default:   w_state_byte = 8'h00;
        endcase
    end

    // Sample storage; writes are suppressed while in reset
    always_ff @(posedge i_Clock) begin
        if (!i_Reset && w_push) begin
            r_mem[r_wr_ptr] <= i_Sample;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= CW'(r_count + 1'b1);
                2'b01:   r_count <= CW'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Packet FSM: presents one byte per state, with a one-cycle DV gap after
    // each acceptance (r_gap) during which the next state's byte is loaded.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state      <= S_IDLE;
            r_gap        <= 1'b0;
            r_tx_dv      <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_pkt_active <= 1'b0;
            r_seq        <= 8'h00;
            r_csum       <= 8'h00;
            r_samp_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_gap <= 1'b0;
                    if (w_pkt_ready) begin
                        r_state      <= S_HDR;
                        r_tx_dv      <= 1'b1;
                        r_tx_byte    <= SYNC_BYTE;
                        r_pkt_active <= 1'b1;
                        r_csum       <= 8'h00;
                        r_samp_cnt   <= '0;
                    end
                end
                default: begin
                    if (r_gap) begin
                        r_gap     <= 1'b0;
                        r_tx_dv   <= 1'b1;
                        r_tx_byte <= w_state_byte;
                    end else if (w_accept) begin
                        r_tx_dv <= 1'b0;
                        r_gap   <= 1'b1;
                        case (r_state)
                            S_HDR: begin
                                r_state <= S_SEQ;
                            end
                            S_SEQ: begin
                                r_state <= S_DATA_HI;
                                r_csum  <= r_csum ^ r_tx_byte;
                            end
                            S_DATA_HI: begin
                                r_state <= S_DATA_LO;
                                r_csum  <= r_csum ^ r_tx_byte;
                            end
                            S_DATA_LO: begin
                                r_csum     <= r_csum ^ r_tx_byte;
                                r_samp_cnt <= SW'(r_samp_cnt + 1'b1);
                                r_state    <= w_last_sample ? S_CSUM : S_DATA_HI;
                            end
                            S_CSUM: begin
                                r_state      <= S_IDLE;
                                r_gap        <= 1'b0;
                                r_pkt_active <= 1'b0;
                                r_seq        <= 8'(r_seq + 1'b1);
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_gap   <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_packetizer.sv
// Scoreboard bench for sample_packetizer: a queue model of the FIFO builds the
// expected byte stream of each packet, which is compared byte by byte as the
// bench accepts bytes from the DUT.
module tb_sample_packetizer;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NB    = 3 + 2 * N;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b0;
    logic [15:0] i_Sample = 16'h0000;
    logic        i_Sample_Valid = 1'b0;
    logic        o_TX_DV;
    logic [7:0]  o_TX_Byte;
    logic        i_TX_Byte_tready = 1'b0;
    logic [4:0]  o_Fifo_Count;
    logic        o_Overflow;
    logic        o_Pkt_Active;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_fifo[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  m_seq = 8'h00;

    sample_packetizer #(
        .PKT_SAMPLES(N),
        .FIFO_DEPTH (DEPTH),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .i_Clock         (i_Clock),
        .i_Reset         (i_Reset),
        .i_Sample        (i_Sample),
        .i_Sample_Valid  (i_Sample_Valid),
        .o_TX_DV         (o_TX_DV),
        .o_TX_Byte       (o_TX_Byte),
        .i_TX_Byte_tready(i_TX_Byte_tready),
        .o_Fifo_Count    (o_Fifo_Count),
        .o_Overflow      (o_Overflow),
        .o_Pkt_Active    (o_Pkt_Active)
    );

    always #5 i_Clock = ~i_Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge i_Clock);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_seq = 8'h00;
    endtask

    task automatic push_sample(input logic [15:0] s);
        i_Sample       = s;
        i_Sample_Valid = 1'b1;
        tick();
        i_Sample_Valid = 1'b0;
        if (m_fifo.size() < DEPTH) m_fifo.push_back(s);
    endtask

    // Wait for a presented byte, compare against the scoreboard, hold for dly
    // cycles, accept it and check the one-cycle DV gap that follows.
    task automatic accept_byte(input int dly, input bit last, input bit poke,
                               input bit push, input logic [15:0] pval,
                               output logic [7:0] seen, output bit ok);
        logic [7:0] exp_b;
        ok   = 1'b1;
        seen = 8'h00;
        for (int c = 0; c < 64 && o_TX_DV !== 1'b1; c++) tick();
        n_vec++;
        if (o_TX_DV !== 1'b1) begin
            $display("FAIL dv_timeout: o_TX_DV=%b required 1", o_TX_DV);
            n_err++;
            ok = 1'b0;
            return;
        end
        if (exp_q.size() == 0) begin
            ok = 1'b0;
            return;
        end
        exp_b = exp_q.pop_front();
        seen  = o_TX_Byte;
        n_vec++;
        if (o_TX_Byte !== exp_b) begin
            $display("FAIL tx_byte: got %02h required %02h", o_TX_Byte, exp_b);
            n_err++;
        end
        for (int d = 0; d < dly; d++) begin
            tick();
            n_vec++;
            if (o_TX_DV !== 1'b1 || o_TX_Byte !== exp_b) begin
                $display("FAIL byte_hold: dv=%b byte=%02h required dv=1 byte=%02h",
                         o_TX_DV, o_TX_Byte, exp_b);
                n_err++;
            end
        end
        i_TX_Byte_tready = 1'b1;
        if (push) begin
            i_Sample       = pval;
            i_Sample_Valid = 1'b1;
        end
        tick();
        i_TX_Byte_tready = 1'b0;
        i_Sample_Valid   = 1'b0;
        n_vec++;
        if (o_TX_DV !== 1'b0) begin
            $display("FAIL gap_dv: o_TX_DV=%b required 0", o_TX_DV);
            n_err++;
        end
        if (last) begin
            n_vec++;
            if (o_Pkt_Active !== 1'b0) begin
                $display("FAIL pkt_active_end: o_Pkt_Active=%b required 0", o_Pkt_Active);
                n_err++;
            end
        end else begin
            if (poke) i_TX_Byte_tready = 1'b1;
            tick();
            i_TX_Byte_tready = 1'b0;
            n_vec++;
            if (o_TX_DV !== 1'b1) begin
                $display("FAIL gap_len: o_TX_DV=%b required 1", o_TX_DV);
                n_err++;
            end
        end
    endtask

    // Build the expected packet from the model FIFO, then accept all its bytes.
    task automatic receive_packet(input int dly, input bit poke, input bit push_lo,
                                  input logic [15:0] pval, output logic [7:0] seq_seen);
        logic [7:0]  c;
        logic [15:0] s;
        logic [7:0]  seen;
        bit          ok;
        seq_seen = 8'hFF;
        if (m_fifo.size() < N) return;
        exp_q.push_back(SYNC);
        exp_q.push_back(m_seq);
        c = m_seq;
        for (int i = 0; i < N; i++) begin
            s = m_fifo.pop_front();
            exp_q.push_back(s[15:8]);
            exp_q.push_back(s[7:0]);
            c = c ^ s[15:8] ^ s[7:0];
        end
        exp_q.push_back(c);
        m_seq = 8'(m_seq + 8'd1);
        for (int i = 0; i < NB; i++) begin
            accept_byte(dly, (i == NB - 1), poke, push_lo && (i == 3), pval, seen, ok);
            if (i == 1) seq_seen = seen;
            if (!ok) begin
                exp_q.delete();
                return;
            end
        end
        if (push_lo) m_fifo.push_back(pval);
    endtask

    task automatic test_reset();
        i_Reset          = 1'b1;
        i_Sample         = 16'hFFFF;
        i_Sample_Valid   = 1'b1;
        i_TX_Byte_tready = 1'b1;
        tick();
        tick();
        n_vec++;
        if (o_TX_DV !== 1'b0) begin
            $display("FAIL reset_dv: got %b required 0", o_TX_DV); n_err++;
        end
        n_vec++;
        if (o_TX_Byte !== 8'h00) begin
            $display("FAIL reset_byte: got %02h required 00", o_TX_Byte); n_err++;
        end
        n_vec++;
        if (o_Fifo_Count !== 5'd0) begin
            $display("FAIL reset_count: got %0d required 0", o_Fifo_Count); n_err++;
        end
        n_vec++;
        if (o_Overflow !== 1'b0) begin
            $display("FAIL reset_ovf: got %b required 0", o_Overflow); n_err++;
        end
        n_vec++;
        if (o_Pkt_Active !== 1'b0) begin
            $display("FAIL reset_active: got %b required 0", o_Pkt_Active); n_err++;
        end
        i_Reset          = 1'b0;
        i_Sample_Valid   = 1'b0;
        i_TX_Byte_tready = 1'b0;
        model_reset();
        tick();
        n_vec++;
        if (o_Fifo_Count !== 5'd0 || o_TX_DV !== 1'b0) begin
            $display("FAIL post_reset: count=%0d dv=%b required count=0 dv=0",
                     o_Fifo_Count, o_TX_DV);
            n_err++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] seen;
        push_sample(16'h1234);
        push_sample(16'h5678);
        push_sample(16'h9ABC);
        push_sample(16'hDEF0);
        receive_packet(2, 1'b0, 1'b0, 16'h0000, seen);
        n_vec++;
        if (seen !== 8'h00) begin
            $display("FAIL basic_seq: got %02h required 00", seen); n_err++;
        end
        tick();
        n_vec++;
        if (o_Fifo_Count !== 5'd0) begin
            $display("FAIL basic_count: got %0d required 0", o_Fifo_Count); n_err++;
        end
    endtask

    task automatic test_idle_tready();
        logic [7:0] seen;
        push_sample(16'h0102);
        push_sample(16'h0304);
        push_sample(16'h0506);
        tick();
        tick();
        n_vec++;
        if (o_Fifo_Count !== 5'd3 || o_TX_DV !== 1'b0) begin
            $display("FAIL idle_pre: count=%0d dv=%b required count=3 dv=0",
                     o_Fifo_Count, o_TX_DV);
            n_err++;
        end
        i_TX_Byte_tready = 1'b1;
        tick();
        i_TX_Byte_tready = 1'b0;
        tick();
        n_vec++;
        if (o_Fifo_Count !== 5'd3 || o_TX_DV !== 1'b0 || o_Pkt_Active !== 1'b0) begin
            $display("FAIL idle_tready: count=%0d dv=%b active=%b required 3/0/0",
                     o_Fifo_Count, o_TX_DV, o_Pkt_Active);
            n_err++;
        end
        push_sample(16'h0708);
        receive_packet(1, 1'b1, 1'b0, 16'h0000, seen);
        n_vec++;
        if (seen !== 8'h01) begin
            $display("FAIL idle_seq: got %02h required 01", seen); n_err++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) push_sample(16'($urandom));
        tick();
        n_vec++;
        if (o_Fifo_Count !== 5'd16) begin
            $display("FAIL ovf_count: got %0d required 16", o_Fifo_Count); n_err++;
        end
        n_vec++;
        if (o_Overflow !== 1'b1) begin
            $display("FAIL ovf_flag: got %b required 1", o_Overflow); n_err++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen;
        for (int p = 0; p < 4; p++) begin
            receive_packet(0, 1'b0, 1'b0, 16'h0000, seen);
            if (p < 3) begin
                tick();
                n_vec++;
                if (o_TX_DV !== 1'b1 || o_TX_Byte !== SYNC) begin
                    $display("FAIL b2b_restart: dv=%b byte=%02h required dv=1 byte=%02h",
                             o_TX_DV, o_TX_Byte, SYNC);
                    n_err++;
                end
            end
        end
        tick();
        tick();
        n_vec++;
        if (o_TX_DV !== 1'b0 || o_Fifo_Count !== 5'd0 || o_Overflow !== 1'b1) begin
            $display("FAIL b2b_drained: dv=%b count=%0d ovf=%b required 0/0/1",
                     o_TX_DV, o_Fifo_Count, o_Overflow);
            n_err++;
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] seen;
        test_reset();
        for (int i = 0; i < 16; i++) push_sample(16'($urandom));
        tick();
        n_vec++;
        if (o_Fifo_Count !== 5'd16 || o_Overflow !== 1'b0) begin
            $display("FAIL full_pre: count=%0d ovf=%b required 16/0", o_Fifo_Count, o_Overflow);
            n_err++;
        end
        receive_packet(1, 1'b0, 1'b1, 16'hBEEF, seen);
        n_vec++;
        if (o_Overflow !== 1'b0 || o_Fifo_Count !== 5'(m_fifo.size())) begin
            $display("FAIL full_pushpop: count=%0d ovf=%b required %0d/0",
                     o_Fifo_Count, o_Overflow, m_fifo.size());
            n_err++;
        end
        for (int p = 0; p < 3; p++) receive_packet(0, 1'b0, 1'b0, 16'h0000, seen);
        tick();
        n_vec++;
        if (o_Fifo_Count !== 5'(m_fifo.size()) || o_Overflow !== 1'b0) begin
            $display("FAIL full_drain: count=%0d ovf=%b required %0d/0",
                     o_Fifo_Count, o_Overflow, m_fifo.size());
            n_err++;
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] seen;
        bit         ok;
        test_reset();
        push_sample(16'h1234);
        push_sample(16'h5678);
        push_sample(16'h9ABC);
        push_sample(16'hDEF0);
        exp_q.push_back(SYNC);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h12);
        for (int i = 0; i < 3; i++) accept_byte(1, 1'b0, 1'b0, 1'b0, 16'h0000, seen, ok);
        n_vec++;
        if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'h34) begin
            $display("FAIL mid_lo: dv=%b byte=%02h required dv=1 byte=34", o_TX_DV, o_TX_Byte);
            n_err++;
        end
        i_Reset        = 1'b1;
        i_Sample       = 16'h7777;
        i_Sample_Valid = 1'b1;
        tick();
        i_Reset        = 1'b0;
        i_Sample_Valid = 1'b0;
        model_reset();
        n_vec++;
        if (o_TX_DV !== 1'b0 || o_Fifo_Count !== 5'd0 || o_Pkt_Active !== 1'b0) begin
            $display("FAIL mid_reset: dv=%b count=%0d active=%b required 0/0/0",
                     o_TX_DV, o_Fifo_Count, o_Pkt_Active);
            n_err++;
        end
        tick();
        n_vec++;
        if (o_Fifo_Count !== 5'd0) begin
            $display("FAIL mid_reset_push: count=%0d required 0", o_Fifo_Count); n_err++;
        end
        push_sample(16'hAAAA);
        push_sample(16'h5555);
        push_sample(16'h0F0F);
        push_sample(16'hF00F);
        receive_packet(0, 1'b0, 1'b0, 16'h0000, seen);
        n_vec++;
        if (seen !== 8'h00) begin
            $display("FAIL mid_reset_seq: got %02h required 00", seen); n_err++;
        end
    endtask

    task automatic test_seq_wrap();
        logic [7:0] seen;
        test_reset();
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < N; i++) push_sample(16'($urandom));
            receive_packet(0, 1'b0, 1'b0, 16'h0000, seen);
            if (p == 255) begin
                n_vec++;
                if (seen !== 8'hFF) begin
                    $display("FAIL seq_255: got %02h required FF", seen); n_err++;
                end
            end
        end
        n_vec++;
        if (seen !== 8'h00) begin
            $display("FAIL seq_wrap: got %02h required 00", seen); n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_tready();
        test_overflow();
        test_back_to_back();
        test_full_push_pop();
        test_mid_reset();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
